// File: rtl/led_pkg.sv
// Shared state codes, FSM encoding and default period values for the LED stage.
package led_pkg;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_RUN   = 2'd1,
    FSM_PAUSE = 2'd2,
    FSM_CLEAR = 2'd3
  } fsm_state_e;

  localparam logic [40:0] SPEED0_DEF = 41'd25000000;
  localparam logic [40:0] SPEED1_DEF = 41'd10000000;
  localparam logic [40:0] SPEED2_DEF = 41'd4000000;
  localparam logic [40:0] SPEED3_DEF = 41'd1000000;

  function automatic logic [1:0] next_speed(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-flop synchronizer, stability debouncer and
// registered single-cycle press pulse on an accepted falling edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, count stable disagreement, flip accepted level, detect press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      level_r   <= 1'b1;
      level_d_r <= 1'b1;
      press_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else begin
      sync1_r   <= key_n;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      press_r   <= level_d_r & ~level_r;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/led_mode_ctrl.sv
// Button front end for the LED pattern engine: run/pause/clear state machine,
// speed selection register and the period value handed downstream.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          CLEAR_CYCLES    = 4,
  parameter logic [40:0] SPEED0          = SPEED0_DEF,
  parameter logic [40:0] SPEED1          = SPEED1_DEF,
  parameter logic [40:0] SPEED2          = SPEED2_DEF,
  parameter logic [40:0] SPEED3          = SPEED3_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_run_n,
  input  logic        key_speed_n,
  input  logic        key_clear_n,
  output logic [1:0]  st,
  output logic [40:0] counter_ch,
  output logic [1:0]  speed_idx
);

  localparam int CCW = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CCW-1:0] CLR_LOAD = CCW'(CLEAR_CYCLES - 1);

  logic           run_p_s;
  logic           speed_p_s;
  logic           clear_p_s;
  fsm_state_e     state_r;
  logic [1:0]     st_r;
  logic [1:0]     speed_idx_r;
  logic [40:0]    counter_ch_r;
  logic [CCW-1:0] clr_cnt_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .rst_n(rst_n), .key_n(key_run_n), .press(run_p_s)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
    .clk(clk), .rst_n(rst_n), .key_n(key_speed_n), .press(speed_p_s)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst_n(rst_n), .key_n(key_clear_n), .press(clear_p_s)
  );

  function automatic logic [40:0] speed_value(input logic [1:0] idx);
    case (idx)
      2'd0:    return SPEED0;
      2'd1:    return SPEED1;
      2'd2:    return SPEED2;
      2'd3:    return SPEED3;
      default: return SPEED0;
    endcase
  endfunction

  // Mode FSM plus speed register; clear wins over run and swallows speed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= FSM_IDLE;
      st_r         <= ST_HOLD;
      clr_cnt_r    <= {CCW{1'b0}};
      speed_idx_r  <= 2'd0;
      counter_ch_r <= SPEED0;
    end else if (state_r == FSM_CLEAR) begin
      if (clr_cnt_r == {CCW{1'b0}}) begin
        state_r <= FSM_IDLE;
        st_r    <= ST_HOLD;
      end else begin
        clr_cnt_r <= clr_cnt_r - CCW'(1);
      end
    end else if (clear_p_s) begin
      state_r   <= FSM_CLEAR;
      st_r      <= ST_CLEAR;
      clr_cnt_r <= CLR_LOAD;
    end else begin
      if (run_p_s) begin
        case (state_r)
          FSM_IDLE:  begin state_r <= FSM_RUN;   st_r <= ST_RUN;  end
          FSM_RUN:   begin state_r <= FSM_PAUSE; st_r <= ST_HOLD; end
          FSM_PAUSE: begin state_r <= FSM_RUN;   st_r <= ST_RUN;  end
          default:   begin state_r <= FSM_IDLE;  st_r <= ST_HOLD; end
        endcase
      end
      if (speed_p_s) begin
        speed_idx_r  <= next_speed(speed_idx_r);
        counter_ch_r <= speed_value(next_speed(speed_idx_r));
      end
    end
  end

  assign st         = st_r;
  assign counter_ch = counter_ch_r;
  assign speed_idx  = speed_idx_r;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed scoreboard bench for led_mode_ctrl with an 8-cycle debounce and 4-cycle clear.
module tb_led_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_run_n = 1'b1;
  logic        key_speed_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [1:0]  st;
  logic [40:0] counter_ch;
  logic [1:0]  speed_idx;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  idx;
    logic [40:0] cc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_state = 0;        // 0 idle, 1 run, 2 pause
  logic [1:0] m_idx = 2'd0;

  led_mode_ctrl #(.DEBOUNCE_CYCLES(8), .CLEAR_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_run_n(key_run_n), .key_speed_n(key_speed_n),
    .key_clear_n(key_clear_n), .st(st), .counter_ch(counter_ch), .speed_idx(speed_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [40:0] period(input logic [1:0] idx);
    case (idx)
      2'd0:    return 41'd25000000;
      2'd1:    return 41'd10000000;
      2'd2:    return 41'd4000000;
      default: return 41'd1000000;
    endcase
  endfunction

  function automatic logic [1:0] m_st();
    return (m_state == 1) ? 2'd1 : 2'd0;
  endfunction

  task automatic push(input logic [1:0] s, input logic [1:0] idx);
    exp_t e;
    e.st  = s;
    e.idx = idx;
    e.cc  = period(idx);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, st=%0d idx=%0d cc=%0d", tag, st, speed_idx, counter_ch);
    end else begin
      e = sb_q.pop_front();
      assert (st === e.st && speed_idx === e.idx && counter_ch === e.cc) else begin
        miscompares++;
        $error("FAIL %s: got st=%0d idx=%0d cc=%0d, expected st=%0d idx=%0d cc=%0d",
               tag, st, speed_idx, counter_ch, e.st, e.idx, e.cc);
      end
    end
  endtask

  // Press keys on one edge, check latency edges, clear window and settled result.
  task automatic press(input string tag, input logic run, input logic spd,
                       input logic clr, input logic spd_late);
    push(m_st(), m_idx);
    if (clr) begin
      m_state = 0;
      repeat (4) push(2'd2, m_idx);
      push(2'd0, m_idx);
    end else begin
      if (run) m_state = (m_state == 1) ? 2 : 1;
      if (spd) m_idx = m_idx + 2'd1;
      push(m_st(), m_idx);
    end
    push(m_st(), m_idx);
    @(negedge clk);
    key_run_n   = ~run;
    key_speed_n = ~spd;
    key_clear_n = ~clr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (spd_late && k == 2) key_speed_n = 1'b0;
      if (k == 11) check({tag, "_pre"});
      if (k == 12) check({tag, "_edge"});
      if (clr && k >= 13 && k <= 16) check({tag, "_clrwin"});
      if (k == 20) begin
        key_run_n = 1'b1; key_speed_n = 1'b1; key_clear_n = 1'b1;
      end
    end
    check({tag, "_final"});
  endtask

  initial begin
    // Reset with keys toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      key_run_n   = 1'($urandom_range(0, 1));
      key_speed_n = 1'($urandom_range(0, 1));
      key_clear_n = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    key_run_n = 1'b1; key_speed_n = 1'b1; key_clear_n = 1'b1;
    push(2'd0, 2'd0);
    check("rst_hold");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(2'd0, 2'd0);
    check("rst_idle");

    // Bounce: low 5, high 3, then held low
    for (int i = 0; i < 5; i++) begin @(negedge clk); key_run_n = 1'b0; end
    for (int i = 0; i < 3; i++) begin @(negedge clk); key_run_n = 1'b1; end
    push(2'd0, 2'd0);
    push(2'd1, 2'd0);
    push(2'd1, 2'd0);
    @(negedge clk);
    key_run_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 11) check("bounce_pre");
      if (k == 12) check("bounce_edge");
      if (k == 20) key_run_n = 1'b1;
    end
    check("bounce_single");

    // Reset back to idle from run
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    push(2'd0, 2'd0);
    check("rst_run");
    rst_n = 1'b1;
    m_state = 0;
    m_idx = 2'd0;

    press("run1", 1'b1, 1'b0, 1'b0, 1'b0);
    press("run2", 1'b1, 1'b0, 1'b0, 1'b0);
    press("run3", 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) press("speed", 1'b0, 1'b1, 1'b0, 1'b0);

    press("clear_spd", 1'b0, 1'b0, 1'b1, 1'b1);

    press("run4", 1'b1, 1'b0, 1'b0, 1'b0);
    press("pause", 1'b1, 1'b0, 1'b0, 1'b0);
    press("run_clear", 1'b1, 1'b0, 1'b1, 1'b0);
    press("run_speed", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
